// File: rtl/motor_dense_serial_mac_16_7.sv
// Serial dense layer, ap_fixed<16,7>: one MAC per clock, results packed per output lane.
// Define MOTOR_DENSE_SAT_EN to saturate outputs instead of the default AP_WRAP behaviour.
module motor_dense_serial_mac_16_7 #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2,
  parameter logic [N_IN*N_OUT*16-1:0] WEIGHTS = '0,
  parameter logic [N_OUT*16-1:0]      BIASES  = '0,
  parameter int ACC_W = 40
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic                  ap_ready,
  input  logic [N_IN*16-1:0]    x_in,
  output logic [N_OUT*16-1:0]   ap_return
);
  localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N_OUT - 1);

  // Packed layouts line up with the flat parameter encoding: element [j][i] sits at (j*N_IN+i)*16.
  localparam logic [N_OUT-1:0][N_IN-1:0][15:0] W_ARR = WEIGHTS;
  localparam logic [N_OUT-1:0][15:0]           B_ARR = BIASES;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  state_t                  state, state_nxt;
  logic [N_IN-1:0][15:0]   x_reg;
  logic [N_OUT-1:0][15:0]  y_q;
  logic [IW-1:0]           i_idx;
  logic [JW-1:0]           j_idx;
  logic signed [ACC_W-1:0] acc, acc_next;
  logic signed [31:0]      prod;

  function automatic logic signed [ACC_W-1:0] bias_acc(input logic [15:0] b);
    return {{(ACC_W-16){b[15]}}, b} << 9;
  endfunction

  function automatic logic [15:0] fmt(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] sh;
    sh = a >>> 9;
`ifdef MOTOR_DENSE_SAT_EN
    if (sh[ACC_W-1:15] != {(ACC_W-15){sh[ACC_W-1]}})
      return sh[ACC_W-1] ? 16'h8000 : 16'h7FFF;
`endif
    return sh[15:0];
  endfunction

  assign prod     = 32'($signed(x_reg[i_idx])) * 32'($signed(W_ARR[j_idx][i_idx]));
  assign acc_next = acc + ACC_W'(prod);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ap_start) state_nxt = S_MAC;
      S_MAC:   if (i_idx == I_LAST && j_idx == J_LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      x_reg <= '0;
      y_q   <= '0;
      acc   <= '0;
      i_idx <= '0;
      j_idx <= '0;
    end else begin
      case (state)
        S_IDLE: if (ap_start) begin
          x_reg <= x_in;
          i_idx <= '0;
          j_idx <= '0;
          acc   <= bias_acc(B_ARR[0]);
        end
        S_MAC: if (i_idx == I_LAST) begin
          y_q[j_idx] <= fmt(acc_next);
          i_idx      <= '0;
          j_idx      <= j_idx + JW'(1);
          // The bias of the following lane seeds its accumulation; nothing follows the last lane.
          if (j_idx != J_LAST) acc <= bias_acc(B_ARR[j_idx + JW'(1)]);
        end else begin
          i_idx <= i_idx + IW'(1);
          acc   <= acc_next;
        end
        default: ;
      endcase
    end
  end

  assign ap_idle   = (state == S_IDLE);
  assign ap_done   = (state == S_DONE);
  assign ap_ready  = (state == S_DONE);
  assign ap_return = y_q;
endmodule

// File: tb/tb_motor_dense_serial_mac_16_7.sv
// Bench for motor_dense_serial_mac_16_7: five weight sets share one stimulus, checked against a plain-arithmetic model.
module tb_motor_dense_serial_mac_16_7;
  localparam int NK = 5;
  localparam logic [127:0] W1 = {8{16'h0100}};
  localparam logic [127:0] W2 = {8{16'hFF00}};
  localparam logic [127:0] W3 = {16'h0, 16'h0, 16'h0, 16'hFF00, 16'h0, 16'h0, 16'h0, 16'h0100};
  localparam logic [127:0] W4 = {8{16'h0200}};
  localparam logic [127:0] W5 = 128'h1234_ABCD_0F0F_8001_7FFF_FE21_00C3_9A55;
  localparam logic [NK-1:0][127:0] WS = {W5, W4, W3, W2, W1};
  localparam logic [NK-1:0][31:0]  BS = {32'h0155_FE33, 32'h0, 32'h0, 32'hFE00_0200, 32'h0};

  logic        ap_clk = 1'b0;
  logic        ap_rst, ap_start;
  logic [63:0] x_in;
  logic [NK-1:0] done, idle, ready;
  logic [31:0] ret [NK];
  int checks = 0, errors = 0;

  always #5 ap_clk = ~ap_clk;

  for (genvar g = 0; g < NK; g++) begin : g_dut
    motor_dense_serial_mac_16_7 #(.N_IN(4), .N_OUT(2), .WEIGHTS(WS[g]), .BIASES(BS[g]), .ACC_W(40)) u_dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_done(done[g]),
      .ap_idle(idle[g]), .ap_ready(ready[g]), .x_in(x_in), .ap_return(ret[g]));
  end

  // y[j] = floor((b[j]*2^9 + sum x[i]*w[j][i]) / 2^9), then wrapped or clamped to 16 bits.
  function automatic logic [31:0] model(input int k, input logic [63:0] x);
    logic [127:0] w;
    logic [31:0]  b, y;
    longint acc, q;
    w = WS[k];
    b = BS[k];
    y = '0;
    for (int j = 0; j < 2; j++) begin
      acc = longint'($signed(b[j*16 +: 16])) * 512;
      for (int i = 0; i < 4; i++)
        acc += longint'($signed(x[i*16 +: 16])) * longint'($signed(w[(j*4+i)*16 +: 16]));
      q = acc >>> 9;
`ifdef MOTOR_DENSE_SAT_EN
      if (q > 32767) q = 32767;
      else if (q < -32768) q = -32768;
`endif
      y[j*16 +: 16] = q[15:0];
    end
    return y;
  endfunction

  // Pulses ap_start for one cycle, scrambles x_in afterwards, returns edges until ap_done (9 expected).
  task automatic run(input logic [63:0] x, output int lat);
    @(negedge ap_clk);
    x_in = x; ap_start = 1'b1; lat = 0;
    @(posedge ap_clk); lat = 1;
    @(negedge ap_clk);
    ap_start = 1'b0; x_in = {$urandom, $urandom};
    while (!done[0] && lat < 30) begin
      @(posedge ap_clk); lat++;
      @(negedge ap_clk);
    end
  endtask

  task automatic test_reset;
    ap_rst = 1'b1; ap_start = 1'b0; x_in = '0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    for (int k = 0; k < NK; k++) begin
      checks++;
      if (ret[k] !== 32'h0 || idle[k] !== 1'b1 || done[k] !== 1'b0 || ready[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d]: ret=%h idle=%b done=%b ready=%b, want ret=0 idle=1 done=0 ready=0",
                 k, ret[k], idle[k], done[k], ready[k]);
      end
    end
    ap_rst = 1'b0;
  endtask

  task automatic test_spec_vectors;
    logic [63:0] xv [4];
    logic [31:0] ev [4];
    int          kv [4];
    int lat;
    xv[0] = {4{16'h0200}}; kv[0] = 0; ev[0] = 32'h0400_0400;
    xv[1] = {4{16'h0200}}; kv[1] = 1; ev[1] = 32'hFA00_FE00;
    xv[2] = 64'h0001;      kv[2] = 2; ev[2] = 32'hFFFF_0000;
    xv[3] = {4{16'h4000}}; kv[3] = 3;
`ifdef MOTOR_DENSE_SAT_EN
    ev[3] = 32'h7FFF_7FFF;
`else
    ev[3] = 32'h0000_0000;
`endif
    for (int v = 0; v < 4; v++) begin
      run(xv[v], lat);
      checks++;
      if (lat != 9 || ready[0] !== 1'b1) begin
        errors++;
        $display("FAIL spec_latency[%0d]: done after %0d edges ready=%b, want 9 edges ready=1", v, lat, ready[0]);
      end
      checks++;
      if (ret[kv[v]] !== ev[v]) begin
        errors++;
        $display("FAIL spec_value[%0d]: got %h, want %h", v, ret[kv[v]], ev[v]);
      end
      for (int k = 0; k < NK; k++) begin
        checks++;
        if (ret[k] !== model(k, xv[v])) begin
          errors++;
          $display("FAIL spec_model[%0d] inst %0d: got %h, want %h", v, k, ret[k], model(k, xv[v]));
        end
      end
    end
  endtask

  task automatic test_random;
    logic [63:0] x;
    int lat;
    for (int n = 0; n < 20; n++) begin
      x = {$urandom, $urandom};
      if (n % 4 == 0) x = {4{16'h7FFF}} ^ {4{16'($urandom_range(0, 1) * 16'hFFFF)}};
      run(x, lat);
      checks++;
      if (lat != 9 || done !== '1 || ready !== '1) begin
        errors++;
        $display("FAIL random_handshake[%0d]: lat=%0d done=%b ready=%b, want lat=9 all ones", n, lat, done, ready);
      end
      for (int k = 0; k < NK; k++) begin
        checks++;
        if (ret[k] !== model(k, x)) begin
          errors++;
          $display("FAIL random_value[%0d] inst %0d x=%h: got %h, want %h", n, k, x, ret[k], model(k, x));
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] xs [4];
    int edges, n;
    for (int i = 0; i < 4; i++) xs[i] = {$urandom, $urandom};
    @(negedge ap_clk);
    x_in = xs[0]; ap_start = 1'b1; edges = 0; n = 0;
    while (n < 3 && edges < 40) begin
      @(posedge ap_clk); edges++;
      @(negedge ap_clk);
      if (done[0]) begin
        checks++;
        if (edges != 9 + 10 * n || ready[0] !== 1'b1) begin
          errors++;
          $display("FAIL b2b_timing[%0d]: done at edge %0d ready=%b, want edge %0d ready=1", n, edges, ready[0], 9 + 10 * n);
        end
        for (int k = 0; k < NK; k++) begin
          checks++;
          if (ret[k] !== model(k, xs[n])) begin
            errors++;
            $display("FAIL b2b_value[%0d] inst %0d: got %h, want %h", n, k, ret[k], model(k, xs[n]));
          end
        end
        n++;
        x_in = xs[n];
      end
    end
    ap_start = 1'b0;
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL b2b_count: saw %0d done pulses within %0d edges, want 3", n, edges);
    end
    @(negedge ap_clk);
  endtask

  task automatic test_ignore_start;
    logic [63:0] xa;
    int lat, extra;
    xa = {$urandom, $urandom};
    @(negedge ap_clk);
    x_in = xa; ap_start = 1'b1; lat = 0;
    while (!done[0] && lat < 30) begin
      @(posedge ap_clk); lat++;
      @(negedge ap_clk);
      x_in = {$urandom, $urandom};
      ap_start = (lat >= 3 && lat <= 6);
      if (lat == 4) begin
        checks++;
        if (idle[0] !== 1'b0) begin
          errors++;
          $display("FAIL ignore_idle: ap_idle=%b during MAC, want 0", idle[0]);
        end
      end
    end
    ap_start = 1'b0;
    checks++;
    if (lat != 9 || ret[4] !== model(4, xa)) begin
      errors++;
      $display("FAIL ignore_run: lat=%0d ret=%h, want lat=9 ret=%h", lat, ret[4], model(4, xa));
    end
    extra = 0;
    repeat (12) begin
      @(posedge ap_clk); @(negedge ap_clk);
      if (done[0]) extra++;
    end
    checks++;
    if (extra != 0 || idle[0] !== 1'b1) begin
      errors++;
      $display("FAIL ignore_extra: %0d extra done pulses idle=%b, want 0 and idle=1", extra, idle[0]);
    end
  endtask

  task automatic test_reset_abort;
    int seen;
    @(negedge ap_clk);
    x_in = {4{16'h0200}}; ap_start = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_start = 1'b0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    for (int k = 0; k < NK; k++) begin
      checks++;
      if (ret[k] !== 32'h0 || idle[k] !== 1'b1 || done[k] !== 1'b0) begin
        errors++;
        $display("FAIL abort_state[%0d]: ret=%h idle=%b done=%b, want ret=0 idle=1 done=0", k, ret[k], idle[k], done[k]);
      end
    end
    seen = 0;
    repeat (15) begin
      @(posedge ap_clk); @(negedge ap_clk);
      if (done != '0) seen++;
    end
    checks++;
    if (seen != 0 || ret[0] !== 32'h0) begin
      errors++;
      $display("FAIL abort_quiet: %0d done cycles ret=%h, want 0 and ret=0", seen, ret[0]);
    end
  endtask

  initial begin
    test_reset;
    test_spec_vectors;
    test_random;
    test_back_to_back;
    test_ignore_start;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
